// File: rtl/carry_skip_adder32_pkg.sv
// Shared sizing constants for the carry-skip adder and its blocks.
// Pure elaboration-time helpers; no logic.
package carry_skip_adder32_pkg;

  localparam int WIDTH_DEFAULT   = 32;
  localparam int BLOCK_W_DEFAULT = 8;

  function automatic int num_blocks(input int width, input int block_w);
    return width / block_w;
  endfunction

endpackage

// File: rtl/carry_skip_adder32_cskip_block.sv
// One carry-skip slice: ripple adder, block propagate, skip mux on the carry-out.
// Combinational, no backpressure.
module cskip_block #(
  parameter int BLOCK_W = 8
) (
  input  logic [BLOCK_W-1:0] a,
  input  logic [BLOCK_W-1:0] b,
  input  logic               cin,
  output logic [BLOCK_W-1:0] sum,
  output logic               cout
);

  logic [BLOCK_W-1:0] p;
  logic [BLOCK_W-1:0] g;
  logic               blk_p;
  logic               carry;
  logic               ripple_cout;

  assign p     = a ^ b;
  assign g     = a & b;
  assign blk_p = &p;

  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < BLOCK_W; i++) begin
      sum[i] = p[i] ^ carry;
      carry  = g[i] | (p[i] & carry);
    end
    ripple_cout = carry;
  end

  // Explicit skip mux: when every bit propagates, bypass the ripple chain.
  assign cout = blk_p ? cin : ripple_cout;

endmodule

// File: rtl/carry_skip_adder32.sv
// Registered {Cout,Sum} = A + B + Cin over a chain of carry-skip blocks.
// Latency 1 cycle, one addition per cycle, no handshake or backpressure.
module carry_skip_adder32
  import carry_skip_adder32_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int BLOCK_W = BLOCK_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int NB = num_blocks(WIDTH, BLOCK_W);

  logic [WIDTH-1:0] sum_comb;
  logic             cout_comb;

  // Each block keeps its own carry nets so the inter-block chain stays a plain
  // path of skip muxes rather than one vector feeding back on itself.
  for (genvar k = 0; k < NB; k++) begin : g_blk
    logic blk_cin;
    logic blk_cout;

    if (k == 0) begin : g_first
      assign blk_cin = Cin;
    end else begin : g_rest
      assign blk_cin = g_blk[k-1].blk_cout;
    end

    cskip_block #(
      .BLOCK_W(BLOCK_W)
    ) u_blk (
      .a   (A[k*BLOCK_W +: BLOCK_W]),
      .b   (B[k*BLOCK_W +: BLOCK_W]),
      .cin (blk_cin),
      .sum (sum_comb[k*BLOCK_W +: BLOCK_W]),
      .cout(blk_cout)
    );
  end

  assign cout_comb = g_blk[NB-1].blk_cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Sum  <= '0;
      Cout <= 1'b0;
    end else begin
      Sum  <= sum_comb;
      Cout <= cout_comb;
    end
  end

endmodule

// File: tb/tb_carry_skip_adder32.sv
// Scoreboard bench for carry_skip_adder32: expected {Cout,Sum} queued at drive
// time, popped one cycle later.
module tb_carry_skip_adder32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic [31:0] Sum;
  logic        Cout;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  carry_skip_adder32 #(
    .WIDTH  (32),
    .BLOCK_W(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .Cin (Cin),
    .Sum (Sum),
    .Cout(Cout)
  );

  function automatic logic [32:0] golden(input logic [31:0] a, input logic [31:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {32'd0, c};
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic [32:0] expv);
    @(negedge clk);
    A   = a;
    B   = b;
    Cin = c;
    exp_q.push_back(expv);
  endtask

  task automatic test_reset();
    logic [32:0] e;
    rst = 1'b1;
    A   = 32'hDEADBEEF;
    B   = 32'h01234567;
    Cin = 1'b1;
    #3;
    checks++;
    if ({Cout, Sum} !== 33'd0) begin
      errors++;
      $display("FAIL reset_init: got %h want %h", {Cout, Sum}, 33'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(32'h12345678, 32'h87654321, 1'b0, {1'b0, 32'h99999999});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if ({Cout, Sum} !== e) begin
      errors++;
      $display("FAIL reset_first_capture: got %h want %h", {Cout, Sum}, e);
    end
    // Load a nonzero result, then hit reset between clock edges.
    drive(32'hF0000000, 32'h20000000, 1'b1, {1'b1, 32'h10000001});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if ({Cout, Sum} !== e) begin
      errors++;
      $display("FAIL reset_preload: got %h want %h", {Cout, Sum}, e);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({Cout, Sum} !== 33'd0) begin
      errors++;
      $display("FAIL reset_async: got %h want %h", {Cout, Sum}, 33'd0);
    end
    @(posedge clk); #1;
    checks++;
    if ({Cout, Sum} !== 33'd0) begin
      errors++;
      $display("FAIL reset_hold: got %h want %h", {Cout, Sum}, 33'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(32'h12345678, 32'h87654321, 1'b0, {1'b0, 32'h99999999});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if ({Cout, Sum} !== e) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", {Cout, Sum}, e);
    end
  endtask

  task automatic test_directed();
    logic [32:0] e;
    logic [31:0] va [5] = '{32'hFFFFFFFF, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 32'h000000FF};
    logic [31:0] vb [5] = '{32'h00000001, 32'h55555555, 32'h55555555, 32'hFFFFFFFF, 32'h00000001};
    logic        vc [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [32:0] ve [5] = '{{1'b1, 32'h00000001}, {1'b0, 32'hFFFFFFFF}, {1'b1, 32'h00000000},
                            {1'b1, 32'h00000000}, {1'b0, 32'h00000100}};
    for (int i = 0; i < 5; i++) begin
      drive(va[i], vb[i], vc[i], ve[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({Cout, Sum} !== e) begin
        errors++;
        $display("FAIL directed_%0d: got %h want %h", i, {Cout, Sum}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] e;
    logic [31:0] va [4] = '{32'hFFFFFFFF, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000};
    logic [31:0] vb [4] = '{32'h00000001, 32'h55555555, 32'h55555555, 32'hFFFFFFFF};
    logic        vc [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [32:0] ve [4] = '{{1'b1, 32'h00000001}, {1'b0, 32'hFFFFFFFF}, {1'b1, 32'h00000000},
                            {1'b1, 32'h00000000}};
    // Two passes so each vector also follows a different predecessor.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        drive(va[(i + r) % 4], vb[(i + r) % 4], vc[(i + r) % 4], ve[(i + r) % 4]);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if ({Cout, Sum} !== e) begin
          errors++;
          $display("FAIL back_to_back_%0d_%0d: got %h want %h", r, i, {Cout, Sum}, e);
        end
      end
    end
  endtask

  task automatic test_block_boundaries();
    logic [32:0] e;
    logic [31:0] a;
    logic [31:0] b;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 2; c++) begin
        a = 32'h000000FF << (8 * k);
        b = 32'h00000001 << (8 * k);
        drive(a, b, c[0], golden(a, b, c[0]));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if ({Cout, Sum} !== e) begin
          errors++;
          $display("FAIL boundary_blk%0d_cin%0d: got %h want %h", k, c, {Cout, Sum}, e);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [32:0] e;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    for (int i = 0; i < 10000; i++) begin
      a = $urandom;
      b = (i % 8 == 0) ? ~a : $urandom;
      c = 1'($urandom_range(0, 1));
      drive(a, b, c, golden(a, b, c));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({Cout, Sum} !== e) begin
        errors++;
        $display("FAIL random_%0d: a=%h b=%h cin=%0d got %h want %h", i, a, b, c, {Cout, Sum}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_block_boundaries();
    test_random();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
